// File: rtl/periph_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : periph_bus_timer
// Purpose  : Memory-mapped peripheral at 0x40000000 on the CPU data bus.
//            Contains a reload timer with IRQ, an LED register, a 7-segment
//            display register and a free-running systick counter.
// Revision : 1.0
// ============================================================================
module periph_bus_timer #(
    parameter logic [31:0] TH_RESET = 32'hFFFF_F000,
    parameter logic [31:0] TL_RESET = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic [11:0] digi,
    output logic [7:0]  led
);

    localparam logic [26:0] BASE_HI     = 27'h200_0000;
    localparam logic [2:0]  OFF_TH      = 3'd0;
    localparam logic [2:0]  OFF_TL      = 3'd1;
    localparam logic [2:0]  OFF_TCON    = 3'd2;
    localparam logic [2:0]  OFF_LED     = 3'd3;
    localparam logic [2:0]  OFF_DIGI    = 3'd4;
    localparam logic [2:0]  OFF_SYSTICK = 3'd5;
    localparam logic [11:0] DIGI_OFF    = 12'hFFF;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;

    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_off;
    logic [1:0]  w_unused_addr;

    assign w_sel         = (Address[31:5] == BASE_HI);
    assign w_wr          = MemWrite & w_sel;
    assign w_rd          = MemRead & w_sel;
    assign w_off         = Address[4:2];
    assign w_unused_addr = Address[1:0];

    // Timer update first; a bus write to the same register overrides it.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (w_wr) begin
            case (w_off)
                OFF_TH:   th_d   = WriteData;
                OFF_TL:   tl_d   = WriteData;
                OFF_TCON: tcon_d = WriteData[2:0];
                OFF_LED:  led_d  = WriteData[7:0];
                OFF_DIGI: digi_d = WriteData[11:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= TH_RESET;
            tl_q      <= TL_RESET;
            tcon_q    <= 3'b000;
            led_q     <= 8'h00;
            digi_q    <= DIGI_OFF;
            systick_q <= 32'd0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (w_rd) begin
            case (w_off)
                OFF_TH:      ReadData = th_q;
                OFF_TL:      ReadData = tl_q;
                OFF_TCON:    ReadData = {29'd0, tcon_q};
                OFF_LED:     ReadData = {24'd0, led_q};
                OFF_DIGI:    ReadData = {20'd0, digi_q};
                OFF_SYSTICK: ReadData = systick_q;
                default:     ReadData = 32'd0;
            endcase
        end
    end

    assign IRQ  = tcon_q[2];
    assign digi = digi_q;
    assign led  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_bus_timer
// Purpose  : Self-checking bench for periph_bus_timer; read expectations go
//            through a scoreboard queue and are compared when data is sampled.
// Revision : 1.0
// ============================================================================
module tb_periph_bus_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        IRQ;
    logic [11:0] digi;
    logic [7:0]  led;

    int total;
    int bad;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    periph_bus_timer dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .IRQ       (IRQ),
        .digi      (digi),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_addr(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        sb_q.push_back('{tag, exp});
        Address = addr;
        MemRead = 1'b1;
        #1;
        e = sb_q.pop_front();
        check(e.tag, ReadData, e.exp);
        MemRead = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
        rd_addr(tag, BASE + {27'd0, off, 2'b00}, exp);
    endtask

    task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        wr_addr(BASE + {27'd0, off, 2'b00}, data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s1;
    logic [31:0] s2;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Reset state
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_digi_out", {20'd0, digi}, 32'h0000_0FFF);
        check("rst_led_out", {24'd0, led}, 32'd0);
        rd("rst_th", 3'd0, 32'hFFFF_F000);
        rd("rst_tl", 3'd1, 32'hFFFF_F000);
        rd("rst_tcon", 3'd2, 32'd0);
        step();
        rd("rst_led", 3'd3, 32'd0);
        rd("rst_digi", 3'd4, 32'h0000_0FFF);
        rd("rst_off6", 3'd6, 32'd0);
        rd("rst_off7", 3'd7, 32'd0);
        step();
        Address = BASE + 32'd20; MemRead = 1'b1; #1; s1 = ReadData; MemRead = 1'b0;
        check("systick_small", {31'd0, (s1 < 32'd20)}, 32'd1);
        step();
        rd("systick_inc", 3'd5, s1 + 32'd1);

        // Count, overflow, reload and sticky IRQ
        wr(3'd0, 32'hFFFF_FFFC);
        wr(3'd1, 32'hFFFF_FFFC);
        wr(3'd2, 32'd3);
        rd("tl_fc", 3'd1, 32'hFFFF_FFFC);
        step(); rd("tl_fd", 3'd1, 32'hFFFF_FFFD);
        step(); rd("tl_fe", 3'd1, 32'hFFFF_FFFE);
        step(); rd("tl_ff", 3'd1, 32'hFFFF_FFFF);
        check("irq_pre_ovf", {31'd0, IRQ}, 32'd0);
        step(); rd("tl_reload", 3'd1, 32'hFFFF_FFFC);
        rd("tcon_7", 3'd2, 32'd7);
        check("irq_set", {31'd0, IRQ}, 32'd1);
        repeat (4) step();
        check("irq_sticky", {31'd0, IRQ}, 32'd1);
        rd("tl_reload2", 3'd1, 32'hFFFF_FFFC);

        // Handler clear and re-arm
        wr(3'd2, 32'd7 & 32'd9);
        check("irq_clr", {31'd0, IRQ}, 32'd0);
        rd("tcon_clr", 3'd2, 32'd1);
        rd("tl_keeps", 3'd1, 32'hFFFF_FFFD);
        wr(3'd2, 32'd3);
        rd("tl_rearm", 3'd1, 32'hFFFF_FFFE);
        step();
        check("irq_wait", {31'd0, IRQ}, 32'd0);
        step();
        check("irq_rearm", {31'd0, IRQ}, 32'd1);

        // Write to TCON in overflow cycle wins, including bit2
        wr(3'd2, 32'd3);
        rd("tl_ovf_a", 3'd1, 32'hFFFF_FFFD);
        step(); step();
        rd("tl_ovf_b", 3'd1, 32'hFFFF_FFFF);
        wr(3'd2, 32'd1);
        rd("tcon_win", 3'd2, 32'd1);
        check("irq_lost", {31'd0, IRQ}, 32'd0);
        rd("tl_ovf_rl", 3'd1, 32'hFFFF_FFFC);
        // Write to TL in overflow cycle loads the written value
        step(); step(); step();
        rd("tl_ovf_c", 3'd1, 32'hFFFF_FFFF);
        wr(3'd1, 32'd5);
        rd("tl_wr_win", 3'd1, 32'd5);
        step();
        rd("tl_after5", 3'd1, 32'd6);
        // Write to TH in overflow cycle: TL takes the old TH
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd0, 32'h0000_0010);
        rd("tl_old_th", 3'd1, 32'hFFFF_FFFC);
        rd("th_new", 3'd0, 32'h0000_0010);
        // Disable holds TL
        wr(3'd2, 32'd0);
        step();
        rd("tl_hold", 3'd1, 32'hFFFF_FFFD);
        // All-ones reload value overflows every cycle
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd2, 32'd3);
        step();
        rd("tl_ones", 3'd1, 32'hFFFF_FFFF);
        check("irq_ones", {31'd0, IRQ}, 32'd1);
        wr(3'd2, 32'd0);

        // Width truncation and read-only systick
        wr(3'd4, 32'h0000_1DC0);
        check("digi_out", {20'd0, digi}, 32'h0000_0DC0);
        rd("digi_rd", 3'd4, 32'h0000_0DC0);
        wr(3'd3, 32'h0000_01A5);
        check("led_out", {24'd0, led}, 32'h0000_00A5);
        rd("led_rd", 3'd3, 32'h0000_00A5);
        wr(3'd2, 32'hFFFF_FFF8);
        rd("tcon_trunc", 3'd2, 32'd0);
        Address = BASE + 32'd20; MemRead = 1'b1; #1; s2 = ReadData; MemRead = 1'b0;
        wr(3'd5, 32'd0);
        rd("systick_ro", 3'd5, s2 + 32'd1);

        // Simultaneous read and write shows pre-write value
        @(negedge clk);
        Address   = BASE + 32'd12;
        WriteData = 32'h0000_003C;
        MemWrite  = 1'b1;
        rd_addr("rw_pre", BASE + 32'd12, 32'h0000_00A5);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        check("rw_post", {24'd0, led}, 32'h0000_003C);

        // Asynchronous reset mid-count
        wr(3'd4, 32'h0000_0123);
        wr(3'd0, 32'h0000_0000);
        wr(3'd2, 32'd7);
        check("irq_forced", {31'd0, IRQ}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_irq", {31'd0, IRQ}, 32'd0);
        check("arst_digi", {20'd0, digi}, 32'h0000_0FFF);
        check("arst_led", {24'd0, led}, 32'd0);
        rd("arst_tcon", 3'd2, 32'd0);
        rd("arst_tl", 3'd1, 32'hFFFF_F000);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Out-of-range accesses
        rd_addr("oor_hi", 32'h4000_0020, 32'd0);
        rd_addr("oor_lo", 32'h0000_0004, 32'd0);
        wr_addr(32'h4000_0024, 32'd5);
        wr_addr(32'h0000_000C, 32'hFF);
        rd("oor_tl", 3'd1, 32'hFFFF_F000);
        check("oor_led", {24'd0, led}, 32'd0);
        Address = BASE;
        MemRead = 1'b0;
        #1;
        check("no_rd", ReadData, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/periph_bus_timer.md
Name: periph_bus_timer

Overview:
- Memory-mapped peripheral responder at base 0x40000000 on the CPU data-memory bus.
- Serves the loads and stores issued by the main program and the interrupt handler.
- Contains a reload timer that raises the CPU interrupt line, a 7-segment display register, an LED register and a free-running systick counter.
- The CPU bus-side address decode selects this block for addresses 0x40000000–0x4000001F. Reads are combinational, like data memory; writes commit on the clock edge.

Parameters:
- TH_RESET, 32'hFFFF_F000, reset value of TH (timer reload value).
- TL_RESET, 32'hFFFF_F000, reset value of TL (timer count).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  bus read strobe.
- MemWrite  input  1  bus write strobe; write commits on the rising edge of clk.
- Address  input  32  byte address; only Address[4:2] is decoded; the block ignores accesses with Address[31:5] != 0x0200_0000.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- IRQ  output  1  interrupt request to the CPU, equal to TCON[2].
- digi  output  12  {AN[3:0] active-low, seg[7:0] active-low} to the display.
- led  output  8  LED register.

Behaviour:
- Register map (word offset = Address[4:2]):
  - 0: TH, R/W, 32 bit.
  - 1: TL, R/W, 32 bit.
  - 2: TCON, R/W, 3 bit; bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status. Reads return {29'b0, TCON}.
  - 3: led, R/W, 8 bit.
  - 4: digi, R/W, 12 bit; reads return {20'b0, digi}.
  - 5: systick, read-only; writes are ignored.
  - 6–7: read 0; writes are ignored.
- ReadData = selected register when MemRead is 1 and the address is in range; otherwise 0. Zero latency.
- Reset (reset = 0, asynchronous):
  - TH = TH_RESET, TL = TL_RESET, TCON = 0, led = 0, digi = 12'hFFF (all off), systick = 0.
  - IRQ = 0.
- systick: increments by 1 every cycle out of reset and wraps at 2^32.
- Timer, evaluated each cycle when TCON[0] = 1:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and if TCON[1] = 1 then TCON[2] <= 1.
  - Otherwise: TL <= TL + 1.
  - When TCON[0] = 0, TL holds.
- TCON[2] is sticky. Only reset or a bus write clears it.
- The interrupt handler clears TCON by writing TCON & 9, which clears bits 1–2. It re-arms by OR-ing in bit 1 (value 2).
- IRQ = TCON[2], registered, with no extra delay.
- Simultaneous events (a bus write and a timer update in the same cycle):
  - Write to TL: the written value is loaded and no increment or reload occurs.
  - Write to TCON while TL overflows: the written value wins for all bits, including bit2 (a set caused by that same overflow is lost).
  - Write to TH while TL overflows: TL reloads with the old TH; the new TH takes effect at the next overflow.
- TH == 32'hFFFF_FFFF with enable set: an overflow occurs every cycle and TL stays at all-ones.
- MemRead and MemWrite both high to the same register: ReadData shows the pre-write value; the write commits at the edge.
- Reset asserted mid-count: all state returns to reset values immediately, without waiting for a clock edge. Reset must be deasserted synchronously by the top level.
- Width rules:
  - Writes to TCON take WriteData[2:0].
  - Writes to led take WriteData[7:0].
  - Writes to digi take WriteData[11:0].
  - Upper bits are discarded.

Test Plan:
1. Reset, then read all offsets 0–7 -> TH = TL = 0xFFFFF000, TCON = 0, led = 0, digi = 0xFFF, systick small and increasing, offsets 6/7 = 0, IRQ = 0.
2. Write TH = 0xFFFFFFFC and TL = 0xFFFFFFFC, then TCON = 3 -> TL reads ...FD, FE, FF on successive cycles, then reloads to FC; TCON = 7 and IRQ = 1 from the cycle after the overflow; further overflows keep IRQ = 1.
3. With IRQ = 1, write TCON = 7 & 9 = 1 -> IRQ = 0 next cycle and the timer keeps counting; then write TCON = 3 -> IRQ rises again at the next overflow.
4. Write TCON = 1 timed in the exact overflow cycle with TCON[1] = 1 -> TCON reads 1 and IRQ stays 0; a write to TL = 5 in an overflow cycle -> TL = 5, not TH.
5. Write digi = 0x1D_C0 (upper bits set) -> digi output and readback = 0xDC0; write led = 0x1A5 -> led = 0xA5; write offset 5 = 0 -> systick is not cleared.
6. Assert reset asynchronously between clock edges while TCON = 7 -> IRQ, TCON and digi go to reset values before the next edge; an address outside 0x40000000–0x4000001F reads 0 and a write there changes nothing.
